clk_divider_prog: RTL and testbench

CLK_DIVIDER_PROG -- requirements
Module: clk_divider_prog

---
 rtl/clk_divider_prog.sv | 102 ++++++++++
 tb/tb_clk_divider_prog.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_divider_prog.sv
// Programmable clock divider: registered clk_out with period D and high phase ceil(D/2).
// New divisors queue as pending and take effect only at a period boundary, so no runt phases.
module clk_divider_prog #(
   parameter int CNT_W     = 16,
   parameter int DIV_RESET = 2
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [CNT_W-1:0] div_val,
   output logic             clk_out,
   output logic             tick,
   output logic             pending,
   output logic             err,
   output logic [CNT_W-1:0] div_active
);

   if (CNT_W < 2 || DIV_RESET < 2 ||
       (CNT_W < 32 && longint'(DIV_RESET) > (longint'(1) << CNT_W) - 1)) begin : g_bad_param
      $error("clk_divider_prog: CNT_W must be >= 2 and DIV_RESET in 2..2^CNT_W-1");
   end

   localparam logic [CNT_W-1:0] L_DIV_RST = CNT_W'(DIV_RESET);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_div;
   logic [CNT_W-1:0] r_pend_div;
   logic             r_pending;
   logic             r_err;
   logic             r_clk_out;
   logic             r_tick;

   logic [CNT_W-1:0] w_half;
   logic [CNT_W-1:0] w_last;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_wrap;
   logic             w_load_ok;

   // D - (D>>1) is ceil(D/2) without the D+1 overflow at D = 2^CNT_W-1.
   assign w_half    = r_div - (r_div >> 1);
   assign w_last    = r_div - CNT_W'(1);
   assign w_cnt_inc = r_cnt + CNT_W'(1);
   assign w_wrap    = (r_cnt == w_last);
   assign w_load_ok = (div_val >= CNT_W'(2));

   always_ff @(posedge clk_in) begin
      if (rst) begin
         r_div      <= L_DIV_RST;
         r_cnt      <= L_DIV_RST - CNT_W'(1);
         r_pend_div <= L_DIV_RST;
         r_pending  <= 1'b0;
         r_err      <= 1'b0;
         r_clk_out  <= 1'b0;
         r_tick     <= 1'b0;
      end else begin
         if (en) begin
            if (w_wrap) begin
               r_cnt     <= '0;
               r_clk_out <= 1'b1;
               r_tick    <= 1'b1;
               if (r_pending) begin
                  r_div     <= r_pend_div;
                  r_pending <= 1'b0;
               end
            end else begin
               r_cnt     <= w_cnt_inc;
               r_clk_out <= (w_cnt_inc < w_half);
               r_tick    <= 1'b0;
            end
         end else begin
            // Parked at D-1 so the first enabled edge is a rising wrap.
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
            if (r_pending) begin
               r_div     <= r_pend_div;
               r_cnt     <= r_pend_div - CNT_W'(1);
               r_pending <= 1'b0;
            end else begin
               r_cnt <= w_last;
            end
         end
         // Placed last: a load on a consuming edge re-arms pending with the new value.
         if (load) begin
            if (w_load_ok) begin
               r_pend_div <= div_val;
               r_pending  <= 1'b1;
               r_err      <= 1'b0;
            end else begin
               r_err <= 1'b1;
            end
         end
      end
   end

   assign clk_out    = r_clk_out;
   assign tick       = r_tick;
   assign pending    = r_pending;
   assign err        = r_err;
   assign div_active = r_div;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Bench for clk_divider_prog: directed period/phase scenarios plus randomized
// stimulus checked cycle-by-cycle against a period-position reference model.
module tb_clk_divider_prog;

   logic clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // DUT A: CNT_W=16, DIV_RESET=2
   logic        rst = 1'b1, en = 1'b0, load = 1'b0;
   logic [15:0] dv = '0;
   logic        co, tk, pd, er;
   logic [15:0] da;

   // DUT B: CNT_W=4, DIV_RESET=3
   logic        rst_b = 1'b1, en_b = 1'b0, load_b = 1'b0;
   logic [3:0]  dv_b = '0;
   logic        co_b, tk_b, pd_b, er_b;
   logic [3:0]  da_b;

   clk_divider_prog #(.CNT_W(16), .DIV_RESET(2)) u_a (
      .clk_in(clk_in), .rst(rst), .en(en), .load(load), .div_val(dv),
      .clk_out(co), .tick(tk), .pending(pd), .err(er), .div_active(da));

   clk_divider_prog #(.CNT_W(4), .DIV_RESET(3)) u_b (
      .clk_in(clk_in), .rst(rst_b), .en(en_b), .load(load_b), .div_val(dv_b),
      .clk_out(co_b), .tick(tk_b), .pending(pd_b), .err(er_b), .div_active(da_b));

   int total = 0;
   int bad   = 0;

   // Reference: position within the current period, 0 = rising cycle.
   typedef struct {
      int d; int p; int pos;
      bit pend; bit err; bit clk; bit tick;
   } mdl_t;

   mdl_t ma;

   function automatic mdl_t mstep(mdl_t m, bit r, bit e, bit l, int v, int drst);
      mdl_t n = m;
      if (r) begin
         n.d = drst; n.p = drst; n.pos = drst - 1;
         n.pend = 0; n.err = 0; n.clk = 0; n.tick = 0;
         return n;
      end
      if (e) begin
         if (m.pos == m.d - 1) begin
            n.pos = 0; n.tick = 1;
            if (m.pend) begin n.d = m.p; n.pend = 0; end
         end else begin
            n.pos = m.pos + 1; n.tick = 0;
         end
         n.clk = (n.pos < (n.d + 1) / 2);
      end else begin
         if (m.pend) begin n.d = m.p; n.pend = 0; end
         n.pos = n.d - 1; n.clk = 0; n.tick = 0;
      end
      if (l) begin
         if (v >= 2) begin n.p = v; n.pend = 1; n.err = 0; end
         else n.err = 1;
      end
      return n;
   endfunction

   task automatic cyc(input bit sel, input bit r, input bit e, input bit l, input int v);
      if (!sel) begin rst = r; en = e; load = l; dv = v[15:0]; end
      else begin rst_b = r; en_b = e; load_b = l; dv_b = v[3:0]; end
      @(posedge clk_in); #1;
      if (!sel) ma = mstep(ma, r, e, l, v, 2);
      load = 1'b0; load_b = 1'b0;
   endtask

   task automatic wait_tick(input bit sel, output bit ok, output int n);
      n = 0;
      do begin
         cyc(sel, 0, 1, 0, 0);
         n++;
      end while (!(sel ? tk_b : tk) && n < 40);
      ok = sel ? tk_b : tk;
   endtask

   // Starts on a rising cycle, ends on the next one.
   task automatic measure(input bit sel, output int hi, output int lo);
      hi = 1; lo = 0;
      cyc(sel, 0, 1, 0, 0);
      while ((sel ? co_b : co) && hi < 100) begin hi++; cyc(sel, 0, 1, 0, 0); end
      while (!(sel ? co_b : co) && lo < 100) begin lo++; cyc(sel, 0, 1, 0, 0); end
   endtask

   task automatic test_reset;
      cyc(0, 1, 1, 1, 5);
      total++;
      if ({co, tk, pd, er} !== 4'b0000 || da !== 16'd2) begin
         bad++; $display("FAIL reset: co/tk/pd/er=%b%b%b%b da=%0d, want 0000 da=2", co, tk, pd, er, da);
      end
   endtask

   task automatic test_div2;
      for (int i = 0; i < 8; i++) begin
         cyc(0, 0, 1, 0, 0);
         total++;
         if (co !== bit'(i % 2 == 0) || tk !== bit'(i % 2 == 0) || da !== 16'd2) begin
            bad++; $display("FAIL div2 cyc%0d: co=%b tk=%b da=%0d, want co=tk=%0d da=2", i, co, tk, da, i % 2 == 0);
         end
      end
   endtask

   task automatic test_change;
      bit ok; int n, hi, lo;
      cyc(0, 0, 1, 1, 4);
      wait_tick(0, ok, n);
      total++;
      if (!ok || da !== 16'd4 || pd !== 1'b0) begin
         bad++; $display("FAIL to_d4: ok=%b da=%0d pd=%b, want 1 4 0", ok, da, pd);
      end
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 1, 1, 5);
      total++;
      if (pd !== 1'b1 || da !== 16'd4) begin
         bad++; $display("FAIL d5_pending: pd=%b da=%0d, want 1 4", pd, da);
      end
      wait_tick(0, ok, n);
      total++;
      if (!ok || n != 2 || da !== 16'd5 || pd !== 1'b0) begin
         bad++; $display("FAIL d5_apply: ok=%b steps=%0d da=%0d pd=%b, want 1 2 5 0", ok, n, da, pd);
      end
      for (int k = 0; k < 2; k++) begin
         measure(0, hi, lo);
         total++;
         if (hi != 3 || lo != 2) begin
            bad++; $display("FAIL d5_shape: hi=%0d lo=%0d, want 3 2", hi, lo);
         end
      end
   endtask

   task automatic test_err;
      bit ok; int n, hi, lo;
      cyc(0, 0, 1, 1, 1);
      total++;
      if (er !== 1'b1 || da !== 16'd5 || pd !== 1'b0) begin
         bad++; $display("FAIL err_div1: er=%b da=%0d pd=%b, want 1 5 0", er, da, pd);
      end
      cyc(0, 0, 1, 1, 0);
      total++;
      if (er !== 1'b1 || da !== 16'd5) begin
         bad++; $display("FAIL err_div0: er=%b da=%0d, want 1 5", er, da);
      end
      wait_tick(0, ok, n);
      measure(0, hi, lo);
      total++;
      if (!ok || hi != 3 || lo != 2) begin
         bad++; $display("FAIL err_shape: ok=%b hi=%0d lo=%0d, want 1 3 2", ok, hi, lo);
      end
      cyc(0, 0, 1, 1, 3);
      total++;
      if (er !== 1'b0 || pd !== 1'b1) begin
         bad++; $display("FAIL err_clear: er=%b pd=%b, want 0 1", er, pd);
      end
   endtask

   task automatic test_en_park;
      int hi, lo;
      cyc(0, 0, 0, 0, 0);
      total++;
      if (da !== 16'd3 || pd !== 1'b0 || co !== 1'b0) begin
         bad++; $display("FAIL park_consume: da=%0d pd=%b co=%b, want 3 0 0", da, pd, co);
      end
      cyc(0, 0, 0, 1, 7);
      cyc(0, 0, 0, 0, 0);
      total++;
      if (da !== 16'd7 || pd !== 1'b0 || co !== 1'b0 || tk !== 1'b0) begin
         bad++; $display("FAIL park_d7: da=%0d pd=%b co=%b tk=%b, want 7 0 0 0", da, pd, co, tk);
      end
      cyc(0, 0, 1, 0, 0);
      total++;
      if (co !== 1'b1 || tk !== 1'b1) begin
         bad++; $display("FAIL en_rise: co=%b tk=%b, want 1 1", co, tk);
      end
      measure(0, hi, lo);
      total++;
      if (hi != 4 || lo != 3) begin
         bad++; $display("FAIL d7_shape: hi=%0d lo=%0d, want 4 3", hi, lo);
      end
   endtask

   task automatic test_overwrite;
      bit ok; int n, hi, lo;
      cyc(0, 0, 1, 1, 3);
      wait_tick(0, ok, n);
      total++;
      if (!ok || da !== 16'd3) begin
         bad++; $display("FAIL to_d3: ok=%b da=%0d, want 1 3", ok, da);
      end
      cyc(0, 0, 1, 1, 6);
      cyc(0, 0, 1, 1, 9);
      total++;
      if (pd !== 1'b1 || da !== 16'd3) begin
         bad++; $display("FAIL ovw_pending: pd=%b da=%0d, want 1 3", pd, da);
      end
      wait_tick(0, ok, n);
      total++;
      if (!ok || n != 1 || da !== 16'd9) begin
         bad++; $display("FAIL ovw_apply: ok=%b steps=%0d da=%0d, want 1 1 9", ok, n, da);
      end
      measure(0, hi, lo);
      total++;
      if (hi != 5 || lo != 4 || da !== 16'd9) begin
         bad++; $display("FAIL d9_shape: hi=%0d lo=%0d da=%0d, want 5 4 9", hi, lo, da);
      end
   endtask

   task automatic test_wide;
      bit ok; int n, hi, lo;
      cyc(1, 1, 1, 0, 0);
      cyc(1, 0, 1, 0, 0);
      total++;
      if (co_b !== 1'b1 || tk_b !== 1'b1 || da_b !== 4'd3) begin
         bad++; $display("FAIL b_first_wrap: co=%b tk=%b da=%0d, want 1 1 3", co_b, tk_b, da_b);
      end
      cyc(1, 0, 1, 1, 15);
      wait_tick(1, ok, n);
      total++;
      if (!ok || da_b !== 4'd15) begin
         bad++; $display("FAIL b_to_d15: ok=%b da=%0d, want 1 15", ok, da_b);
      end
      for (int k = 0; k < 2; k++) begin
         measure(1, hi, lo);
         total++;
         if (hi != 8 || lo != 7) begin
            bad++; $display("FAIL b_d15_shape: hi=%0d lo=%0d, want 8 7", hi, lo);
         end
      end
      cyc(1, 0, 1, 0, 0);
      cyc(1, 0, 1, 1, 5);
      cyc(1, 1, 1, 1, 6);
      total++;
      if (da_b !== 4'd3 || pd_b !== 1'b0 || co_b !== 1'b0 || tk_b !== 1'b0) begin
         bad++; $display("FAIL b_mid_reset: da=%0d pd=%b co=%b tk=%b, want 3 0 0 0", da_b, pd_b, co_b, tk_b);
      end
   endtask

   task automatic test_random;
      bit r, e, l; int v;
      cyc(0, 1, 1, 0, 0);
      for (int i = 0; i < 600; i++) begin
         r = ($urandom_range(0, 99) == 0);
         e = ($urandom_range(0, 9) != 0);
         l = ($urandom_range(0, 5) == 0);
         v = $urandom_range(0, 12);
         cyc(0, r, e, l, v);
         total++;
         if (co !== ma.clk || tk !== ma.tick || pd !== ma.pend || er !== ma.err || da !== 16'(ma.d)) begin
            bad++;
            $display("FAIL rand cyc%0d: co/tk/pd/er=%b%b%b%b da=%0d, want %b%b%b%b da=%0d",
                     i, co, tk, pd, er, da, ma.clk, ma.tick, ma.pend, ma.err, ma.d);
         end
      end
   endtask

   initial begin
      test_reset;
      test_div2;
      test_change;
      test_err;
      test_en_park;
      test_overwrite;
      test_wide;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
